// File: rtl/mux_arbiter.sv
// Round-robin 16-way arbiter that drives the select of a 16:1 mux.
// The owner is rotated out after MAX_HOLD cycles once another requester is waiting.
//
// state | meaning
// IDLE  | no owner; gnt=0, busy=0, sel keeps the last owner
// GRANT | requester r_cur owns the mux; gnt one-hot, busy=1
module mux_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t      r_state;
  logic [3:0]  r_ptr;
  logic [3:0]  r_cur;
  logic [3:0]  r_hold;
  logic [15:0] r_gnt;
  logic [3:0]  r_sel;
  logic        r_busy;

  logic [15:0] w_others;
  logic        w_release;
  logic [3:0]  w_next_ptr;
  logic [3:0]  w_idle_win;
  logic [3:0]  w_rel_win;

  // First set bit of mask, searching upward from start with wrap 15 -> 0.
  function automatic logic [3:0] winner(input logic [15:0] mask, input logic [3:0] start);
    logic [3:0] idx;
    logic       found;
    winner = start;
    found  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = start + 4'(k);
      if (!found && mask[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  endfunction

  assign w_others   = req & ~(16'(1) << r_cur);
  assign w_release  = !req[r_cur] || ((r_hold == HOLD_MAX) && (|w_others));
  assign w_next_ptr = r_cur + 4'd1;
  assign w_idle_win = winner(req, r_ptr);
  // Handover uses the already-advanced pointer so the releasing owner goes last.
  assign w_rel_win  = winner(w_others, w_next_ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 4'd0;
      r_cur   <= 4'd0;
      r_hold  <= 4'd0;
      r_gnt   <= 16'd0;
      r_sel   <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state <= GRANT;
            r_cur   <= w_idle_win;
            r_gnt   <= 16'(1) << w_idle_win;
            r_sel   <= w_idle_win;
            r_hold  <= 4'd1;
            r_busy  <= 1'b1;
          end else begin
            r_gnt  <= 16'd0;
            r_busy <= 1'b0;
          end
        end
        GRANT: begin
          if (!w_release) begin
            if (r_hold < HOLD_MAX) r_hold <= r_hold + 4'd1;
          end else begin
            r_ptr <= w_next_ptr;
            if (|w_others) begin
              r_cur  <= w_rel_win;
              r_gnt  <= 16'(1) << w_rel_win;
              r_sel  <= w_rel_win;
              r_hold <= 4'd1;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 16'd0;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;

endmodule
